mt_ckpt: RTL and testbench

MT_CKPT -- requirements
Module: mt_ckpt

---
 rtl/mt_pkg.sv | 18 +
 rtl/mt_ckpt_fifo.sv | 78 +++++++
 rtl/mt_ckpt.sv | 148 ++++++++++++++
 tb/tb_mt_ckpt.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt_pkg.sv
// Shared parameter defaults and width helper for the rename map and its checkpoint store.
package mt_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int NUM_AR_DEF  = 32;
  localparam int NUM_PR_DEF  = 64;
  localparam int DW_DEF      = 2;
  localparam int CW_DEF      = 6;
  localparam int NCK_DEF     = 4;
  localparam int ZERO_AR_DEF = 31;

endpackage

// File: rtl/mt_ckpt_fifo.sv
// Circular store of map-table snapshots: take pushes at tail, free pops head,
// recover truncates the tail to just past the restored entry.
module mt_ckpt_fifo
  import mt_pkg::*;
#(
  parameter int NCK = NCK_DEF,
  parameter int SW  = 8,
  localparam int CKW = clog2(NCK)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           take,
  input  logic           free,
  input  logic           recover,
  input  logic [CKW-1:0] recover_id,
  input  logic [SW-1:0]  wr_map,
  output logic [SW-1:0]  rd_map,
  output logic [CKW-1:0] ckpt_id,
  output logic           full,
  output logic           empty,
  output logic           overflow
);

  localparam logic [CKW:0] NCK_P = (CKW + 1)'(NCK);
  localparam logic [CKW:0] ONE   = (CKW + 1)'(1);

  logic [SW-1:0]  ckpt_mem [NCK];
  logic [CKW:0]   head_q, head_d, tail_q, tail_d;
  logic           ovf_q, ovf_d;
  logic           wr_en;
  logic [CKW-1:0] offset;
  logic [CKW:0]   count;

  assign count    = tail_q - head_q;
  assign full     = (count == NCK_P);
  assign empty    = (count == '0);
  assign overflow = ovf_q;
  assign ckpt_id  = tail_q[CKW-1:0];
  assign rd_map   = ckpt_mem[recover_id];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    ovf_d  = ovf_q;
    wr_en  = 1'b0;
    offset = '0;
    if (free && !empty) head_d = head_q + ONE;
    // New tail is measured from the old head so the wrap bit stays consistent.
    if (recover) begin
      offset = recover_id - head_q[CKW-1:0];
      tail_d = head_q + {1'b0, offset} + ONE;
    end else if (take) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en  = 1'b1;
        tail_d = tail_q + ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_en) ckpt_mem[tail_q[CKW-1:0]] <= wr_map;
  end

endmodule

// File: rtl/mt_ckpt.sv
// Register rename map with per-PR ready bits, intra-group bypass and
// checkpoint/recover support for branch mispredicts.
module mt_ckpt
  import mt_pkg::*;
#(
  parameter int NUM_AR  = NUM_AR_DEF,
  parameter int NUM_PR  = NUM_PR_DEF,
  parameter int DW      = DW_DEF,
  parameter int CW      = CW_DEF,
  parameter int NCK     = NCK_DEF,
  parameter int ZERO_AR = ZERO_AR_DEF,
  localparam int ARW = clog2(NUM_AR),
  localparam int PRW = clog2(NUM_PR),
  localparam int CKW = clog2(NCK)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DW-1:0]     disp_valid,
  input  logic [DW-1:0]     disp_dest_valid,
  input  logic [DW*ARW-1:0] disp_dest_ar,
  input  logic [DW*ARW-1:0] disp_src1_ar,
  input  logic [DW*ARW-1:0] disp_src2_ar,
  input  logic [DW*PRW-1:0] disp_new_pr,
  output logic [DW*PRW-1:0] src1_pr,
  output logic [DW*PRW-1:0] src2_pr,
  output logic [DW-1:0]     src1_ready,
  output logic [DW-1:0]     src2_ready,
  output logic [DW*PRW-1:0] told_pr,
  input  logic [CW-1:0]     cdb_valid,
  input  logic [CW*PRW-1:0] cdb_pr,
  input  logic              ckpt_take,
  output logic [CKW-1:0]    ckpt_id,
  input  logic              ckpt_free,
  input  logic              recover,
  input  logic [CKW-1:0]    recover_id,
  output logic              ckpt_full,
  output logic              ckpt_empty,
  output logic              ckpt_overflow
);

  localparam logic [ARW-1:0] ZA = ARW'(ZERO_AR);
  localparam int SW = NUM_AR * PRW;

  logic [PRW-1:0]    map_q [NUM_AR];
  logic [PRW-1:0]    map_d [NUM_AR];
  logic [NUM_PR-1:0] ready_q, ready_d;
  logic [SW-1:0]     wr_map, rd_map;
  logic [PRW:0]      rd_s1 [DW];
  logic [PRW:0]      rd_s2 [DW];
  logic [PRW:0]      rd_told [DW];

  function automatic logic cdb_hit(input logic [PRW-1:0] pr);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CW; k++)
      if (cdb_valid[k] && cdb_pr[k*PRW +: PRW] == pr) hit = 1'b1;
    return hit;
  endfunction

  // Returns {bypassed, pr}; later older slots overwrite earlier ones so the youngest wins.
  function automatic logic [PRW:0] rename_rd(input logic [ARW-1:0] ar, input int j);
    logic [PRW-1:0] pr;
    logic           byp;
    pr  = map_q[ar];
    byp = 1'b0;
    if (ar != ZA) begin
      for (int i = 0; i < j; i++) begin
        if (disp_valid[i] && disp_dest_valid[i] && disp_dest_ar[i*ARW +: ARW] == ar) begin
          pr  = disp_new_pr[i*PRW +: PRW];
          byp = 1'b1;
        end
      end
    end
    return {byp, pr};
  endfunction

  always_comb begin
    src1_pr    = '0;
    src2_pr    = '0;
    told_pr    = '0;
    src1_ready = '0;
    src2_ready = '0;
    rd_s1      = '{default: '0};
    rd_s2      = '{default: '0};
    rd_told    = '{default: '0};
    for (int j = 0; j < DW; j++) begin
      rd_s1[j]   = rename_rd(disp_src1_ar[j*ARW +: ARW], j);
      rd_s2[j]   = rename_rd(disp_src2_ar[j*ARW +: ARW], j);
      rd_told[j] = rename_rd(disp_dest_ar[j*ARW +: ARW], j);
      src1_pr[j*PRW +: PRW] = rd_s1[j][PRW-1:0];
      src2_pr[j*PRW +: PRW] = rd_s2[j][PRW-1:0];
      told_pr[j*PRW +: PRW] = rd_told[j][PRW-1:0];
      src1_ready[j] = (disp_src1_ar[j*ARW +: ARW] == ZA) |
                      (~rd_s1[j][PRW] & (ready_q[rd_s1[j][PRW-1:0]] | cdb_hit(rd_s1[j][PRW-1:0])));
      src2_ready[j] = (disp_src2_ar[j*ARW +: ARW] == ZA) |
                      (~rd_s2[j][PRW] & (ready_q[rd_s2[j][PRW-1:0]] | cdb_hit(rd_s2[j][PRW-1:0])));
    end
  end

  always_comb begin
    map_d   = map_q;
    ready_d = ready_q;
    wr_map  = '0;
    for (int k = 0; k < CW; k++)
      if (cdb_valid[k]) ready_d[cdb_pr[k*PRW +: PRW]] = 1'b1;
    if (recover) begin
      for (int i = 0; i < NUM_AR; i++) map_d[i] = rd_map[i*PRW +: PRW];
    end else begin
      // Clears come after CDB sets so a reallocated PR is never left ready.
      for (int j = 0; j < DW; j++) begin
        if (disp_valid[j] && disp_dest_valid[j] && disp_dest_ar[j*ARW +: ARW] != ZA) begin
          map_d[disp_dest_ar[j*ARW +: ARW]]   = disp_new_pr[j*PRW +: PRW];
          ready_d[disp_new_pr[j*PRW +: PRW]] = 1'b0;
        end
      end
    end
    for (int i = 0; i < NUM_AR; i++) wr_map[i*PRW +: PRW] = map_d[i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_AR; i++) map_q[i] <= PRW'(i);
      ready_q <= '1;
    end else begin
      map_q   <= map_d;
      ready_q <= ready_d;
    end
  end

  mt_ckpt_fifo #(
    .NCK (NCK),
    .SW  (SW)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .take       (ckpt_take),
    .free       (ckpt_free),
    .recover    (recover),
    .recover_id (recover_id),
    .wr_map     (wr_map),
    .rd_map     (rd_map),
    .ckpt_id    (ckpt_id),
    .full       (ckpt_full),
    .empty      (ckpt_empty),
    .overflow   (ckpt_overflow)
  );

endmodule

// File: tb/tb_mt_ckpt.sv
// Directed bench for mt_ckpt: expectations queued with each stimulus step, popped at the sample point.
module tb_mt_ckpt;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  disp_valid, disp_dest_valid;
  logic [9:0]  disp_dest_ar, disp_src1_ar, disp_src2_ar;
  logic [11:0] disp_new_pr;
  logic [11:0] src1_pr, src2_pr, told_pr;
  logic [1:0]  src1_ready, src2_ready;
  logic [5:0]  cdb_valid;
  logic [35:0] cdb_pr;
  logic        ckpt_take, ckpt_free, recover;
  logic [1:0]  recover_id, ckpt_id;
  logic        ckpt_full, ckpt_empty, ckpt_overflow;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  hd;

  mt_ckpt dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_dest_valid(disp_dest_valid),
    .disp_dest_ar(disp_dest_ar), .disp_src1_ar(disp_src1_ar), .disp_src2_ar(disp_src2_ar),
    .disp_new_pr(disp_new_pr),
    .src1_pr(src1_pr), .src2_pr(src2_pr), .src1_ready(src1_ready), .src2_ready(src2_ready),
    .told_pr(told_pr),
    .cdb_valid(cdb_valid), .cdb_pr(cdb_pr),
    .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .ckpt_free(ckpt_free),
    .recover(recover), .recover_id(recover_id),
    .ckpt_full(ckpt_full), .ckpt_empty(ckpt_empty), .ckpt_overflow(ckpt_overflow)
  );

  always #5 clock = ~clock;

  task automatic idle();
    disp_valid = '0; disp_dest_valid = '0;
    disp_dest_ar = '0; disp_src1_ar = '0; disp_src2_ar = '0; disp_new_pr = '0;
    cdb_valid = '0; cdb_pr = '0;
    ckpt_take = 1'b0; ckpt_free = 1'b0; recover = 1'b0; recover_id = '0;
  endtask

  task automatic slot(input int j, input logic v, input logic dv, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [5:0] np);
    disp_valid[j] = v;
    disp_dest_valid[j] = dv;
    disp_dest_ar[j*5 +: 5] = d;
    disp_src1_ar[j*5 +: 5] = s1;
    disp_src2_ar[j*5 +: 5] = s2;
    disp_new_pr[j*6 +: 6] = np;
  endtask

  task automatic cdb(input int k, input logic [5:0] pr);
    cdb_valid[k] = 1'b1;
    cdb_pr[k*6 +: 6] = pr;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    idle();
    hd = '0;
    reset = 1'b1;
    // Activity during reset must be overridden.
    slot(0, 1, 1, 3, 0, 0, 50); ckpt_take = 1'b1; cdb(0, 50);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle();

    // Reset state and plain reads.
    slot(0, 0, 0, 5, 5, 31, 0); slot(1, 0, 0, 3, 3, 7, 0);
    push("rst_empty", 1); push("rst_full", 0); push("rst_ovf", 0); push("rst_id", 0);
    push("rst_src1_pr", 5); push("rst_src1_rdy", 1); push("rst_told", 5);
    push("rst_zero_pr", 31); push("rst_zero_rdy", 1); push("rst_r3_map", 3);
    #1;
    pop_chk(ckpt_empty); pop_chk(ckpt_full); pop_chk(ckpt_overflow); pop_chk(ckpt_id);
    pop_chk(src1_pr[5:0]); pop_chk(src1_ready[0]); pop_chk(told_pr[5:0]);
    pop_chk(src2_pr[5:0]); pop_chk(src2_ready[0]); pop_chk(src1_pr[11:6]);
    step();

    // Intra-group bypass, same AR in both slots.
    idle();
    slot(0, 1, 1, 3, 3, 9, 40); slot(1, 1, 1, 3, 3, 7, 41);
    push("s0_src1_pr", 3); push("s0_src1_rdy", 1); push("byp_src1_pr", 40);
    push("byp_src1_rdy", 0); push("byp_told", 40); push("s0_told", 3);
    push("s1_src2_pr", 7); push("s1_src2_rdy", 1);
    #1;
    pop_chk(src1_pr[5:0]); pop_chk(src1_ready[0]); pop_chk(src1_pr[11:6]);
    pop_chk(src1_ready[1]); pop_chk(told_pr[11:6]); pop_chk(told_pr[5:0]);
    pop_chk(src2_pr[11:6]); pop_chk(src2_ready[1]);
    step();

    // Youngest wins; also rename r4 -> 40.
    idle();
    slot(0, 1, 1, 4, 3, 4, 40);
    push("youngest_r3_pr", 41); push("youngest_r3_rdy", 0); push("r4_pr", 4); push("r4_told", 4);
    #1;
    pop_chk(src1_pr[5:0]); pop_chk(src1_ready[0]); pop_chk(src2_pr[5:0]); pop_chk(told_pr[5:0]);
    step();

    // CDB same-cycle forwarding.
    idle();
    slot(0, 0, 0, 0, 4, 0, 0);
    push("pending_pr", 40); push("pending_rdy", 0);
    #1;
    pop_chk(src1_pr[5:0]); pop_chk(src1_ready[0]);
    cdb(2, 40);
    push("cdb_fwd_rdy", 1);
    #1;
    pop_chk(src1_ready[0]);
    step();

    // Ready latched; bypassed source stays not-ready under a matching CDB; clear beats set.
    idle();
    slot(0, 1, 1, 5, 4, 0, 45); slot(1, 1, 1, 6, 5, 0, 46);
    cdb(0, 45); cdb(5, 46);
    push("cdb_latched_rdy", 1); push("byp_cdb_pr", 45); push("byp_cdb_rdy", 0);
    #1;
    pop_chk(src1_ready[0]); pop_chk(src1_pr[11:6]); pop_chk(src1_ready[1]);
    step();
    idle();
    slot(0, 0, 0, 0, 5, 6, 0);
    push("clr_win_r5_pr", 45); push("clr_win_r5_rdy", 0); push("clr_win_r6_pr", 46); push("clr_win_r6_rdy", 0);
    #1;
    pop_chk(src1_pr[5:0]); pop_chk(src1_ready[0]); pop_chk(src2_pr[5:0]); pop_chk(src2_ready[0]);
    step();

    // Checkpoint then recover.
    idle();
    slot(0, 1, 1, 3, 3, 0, 40); ckpt_take = 1'b1;
    push("take_id", 0); push("take_empty_pre", 1);
    #1;
    pop_chk(ckpt_id); pop_chk(ckpt_empty);
    step();
    idle();
    slot(0, 1, 1, 3, 3, 0, 50);
    push("after_take_id", 1); push("after_take_empty", 0); push("post_disp_r3", 40);
    #1;
    pop_chk(ckpt_id); pop_chk(ckpt_empty); pop_chk(src1_pr[5:0]);
    step();
    idle();
    slot(0, 1, 1, 3, 3, 0, 55); ckpt_take = 1'b1; recover = 1'b1; recover_id = 2'd0; cdb(1, 50);
    push("pre_rec_r3", 50);
    #1;
    pop_chk(src1_pr[5:0]);
    step();
    idle();
    slot(0, 0, 0, 0, 3, 4, 0);
    push("rec_r3_pr", 40); push("rec_r3_rdy", 0); push("rec_r4_pr", 40);
    push("rec_empty", 0); push("rec_id", 1);
    #1;
    pop_chk(src1_pr[5:0]); pop_chk(src1_ready[0]); pop_chk(src2_pr[5:0]);
    pop_chk(ckpt_empty); pop_chk(ckpt_id);
    step();

    // Reset restores map and ready bits.
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    hd = '0;
    slot(0, 0, 0, 0, 3, 4, 0);
    push("rst2_r3", 3); push("rst2_r4_rdy", 1); push("rst2_id", 0);
    #1;
    pop_chk(src1_pr[5:0]); pop_chk(src2_ready[0]); pop_chk(ckpt_id);

    // Fill, overflow, drain.
    for (int i = 0; i < 4; i++) begin
      idle(); ckpt_take = 1'b1;
      push("fill_id", i); push("fill_full", 0);
      #1;
      pop_chk(ckpt_id); pop_chk(ckpt_full);
      step();
    end
    idle();
    push("full_after_4", 1); push("id_wrap", 0);
    #1;
    pop_chk(ckpt_full); pop_chk(ckpt_id);
    ckpt_take = 1'b1;
    step();
    idle();
    push("ovf_set", 1); push("ovf_full", 1); push("ovf_id", 0);
    #1;
    pop_chk(ckpt_overflow); pop_chk(ckpt_full); pop_chk(ckpt_id);
    for (int i = 0; i < 4; i++) begin
      idle(); ckpt_free = 1'b1; hd = hd + 2'd1;
      step();
    end
    idle();
    push("drain_empty", 1); push("drain_full", 0); push("drain_id", 0); push("ovf_sticky", 1);
    #1;
    pop_chk(ckpt_empty); pop_chk(ckpt_full); pop_chk(ckpt_id); pop_chk(ckpt_overflow);

    // Free while empty is ignored: four more takes must read full again.
    ckpt_free = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      idle(); ckpt_take = 1'b1;
      step();
    end
    idle();
    push("two_taken_full", 0); push("two_taken_id", 2);
    #1;
    pop_chk(ckpt_full); pop_chk(ckpt_id);
    for (int i = 0; i < 2; i++) begin
      idle(); ckpt_take = 1'b1;
      step();
    end
    idle();
    push("empty_free_ignored_full", 1);
    #1;
    pop_chk(ckpt_full);

    // Recover together with free.
    ckpt_free = 1'b1; recover = 1'b1; recover_id = 2'd2;
    assert (!(ckpt_free && recover && recover_id == hd)) else $error("illegal recover onto freed head");
    hd = hd + 2'd1;
    step();
    idle();
    slot(0, 0, 0, 0, 3, 0, 0);
    push("recfree_full", 0); push("recfree_empty", 0); push("recfree_id", 3); push("recfree_r3", 3);
    #1;
    pop_chk(ckpt_full); pop_chk(ckpt_empty); pop_chk(ckpt_id); pop_chk(src1_pr[5:0]);
    ckpt_free = 1'b1;
    step();
    idle();
    push("recfree_one_left", 0);
    #1;
    pop_chk(ckpt_empty);
    ckpt_free = 1'b1;
    step();
    idle();
    push("recfree_drained", 1);
    #1;
    pop_chk(ckpt_empty);

    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    push("rst3_ovf", 0);
    #1;
    pop_chk(ckpt_overflow);

    // Zero register destination leaves map and ready alone.
    slot(0, 1, 1, 8, 0, 0, 60);
    step();
    idle(); cdb(0, 60);
    step();
    idle();
    slot(0, 1, 1, 31, 0, 0, 60);
    push("zero_told", 31);
    #1;
    pop_chk(told_pr[5:0]);
    step();
    idle();
    slot(0, 0, 0, 0, 8, 31, 0);
    push("zero_r8_pr", 60); push("zero_ready60", 1); push("zero_map31", 31); push("zero_rdy31", 1);
    #1;
    pop_chk(src1_pr[5:0]); pop_chk(src1_ready[0]); pop_chk(src2_pr[5:0]); pop_chk(src2_ready[0]);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
